// File: rtl/instr_fetch_issue.sv
// instr_fetch_issue: single-outstanding instruction fetcher with a 2-entry issue FIFO and redirect flush
module instr_fetch_issue #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] issue_pc,
  output logic [1:0]        fifo_count
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;
  logic [0:0]        state;
  logic              drop;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       w0, w1;
  logic [ADDR_W-1:0] a0, a1;
  logic [1:0]        count;
  logic              pop, ack, push, start;
  logic [1:0]        cnt_pop, cnt_next;
  logic [ADDR_W-1:0] fetch_pc;
  always_comb begin
    pop      = issue_valid & issue_ready;
    ack      = (state == REQ) & mem_ack;
    push     = ack & ~drop & ~redirect;
    cnt_pop  = count - {1'b0, pop};
    cnt_next = redirect ? 2'd0 : cnt_pop + {1'b0, push};
    start    = run & (cnt_next < 2'd2) & ((state == IDLE) | mem_ack);
    fetch_pc = redirect ? redirect_pc : pc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_addr <= '0;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      count    <= 2'd0;
      w0       <= '0;
      w1       <= '0;
      a0       <= '0;
      a1       <= '0;
    end else begin
      state    <= start ? REQ : (ack ? IDLE : state);
      mem_addr <= start ? fetch_pc : mem_addr;
      pc       <= start ? fetch_pc + 1'b1 : fetch_pc;
      // an unacked request survives a redirect; its data is dropped on arrival
      drop     <= ack ? 1'b0 : ((state == REQ) & (drop | redirect));
      count    <= cnt_next;
      if (pop) begin
        w0 <= w1;
        a0 <= a1;
      end
      if (push && cnt_pop == 2'd0) begin
        w0 <= mem_rdata;
        a0 <= mem_addr;
      end
      if (push && cnt_pop != 2'd0) begin
        w1 <= mem_rdata;
        a1 <= mem_addr;
      end
    end
  end
  assign mem_req     = state;
  assign issue_valid = (count != 2'd0);
  assign fifo_count  = count;
  assign opcode      = w0[31:26];
  assign rs          = w0[25:21];
  assign rt          = w0[20:16];
  assign rd          = w0[15:11];
  assign imm         = w0[15:0];
  assign issue_pc    = a0;
endmodule

// File: tb/tb_instr_fetch_issue.sv
// tb_instr_fetch_issue: directed scenario tests for instr_fetch_issue with a zero-wait/manual memory model
module tb_instr_fetch_issue;
  logic        clk = 0, rst_n = 0, run = 0, redirect = 0, issue_ready = 0;
  logic        auto_ack = 1, man_ack = 0, one = 1;
  logic [7:0]  redirect_pc = 0;
  logic        mem_req, mem_ack, issue_valid;
  logic [7:0]  mem_addr, issue_pc;
  logic [31:0] mem_rdata;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [1:0]  fifo_count;
  logic        mem_req2, mem_ack2, issue_valid2;
  logic [7:0]  mem_addr2, issue_pc2;
  logic [31:0] mem_rdata2;
  logic [5:0]  opcode2;
  logic [4:0]  rs2, rt2, rd2;
  logic [15:0] imm2;
  logic [1:0]  fifo_count2;
  int passed = 0, total = 0, acks = 0;

  function automatic logic [31:0] rom(input logic [7:0] a);
    return a == 8'd0 ? 32'h0000_0000 : a == 8'd1 ? 32'h2001_0005 : {6'h0C, 18'h0, a};
  endfunction

  assign mem_ack    = auto_ack ? mem_req : man_ack;
  assign mem_rdata  = rom(mem_addr);
  assign mem_ack2   = mem_req2;
  assign mem_rdata2 = rom(mem_addr2);

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_req && mem_ack) acks <= acks + 1;

  instr_fetch_issue #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .imm(imm), .issue_pc(issue_pc), .fifo_count(fifo_count));

  instr_fetch_issue #(.ADDR_W(8), .RESET_PC(8'hFE)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_ack2), .mem_rdata(mem_rdata2), .redirect(1'b0), .redirect_pc(8'h00),
    .issue_valid(issue_valid2), .issue_ready(one), .opcode(opcode2), .rs(rs2), .rt(rt2),
    .rd(rd2), .imm(imm2), .issue_pc(issue_pc2), .fifo_count(fifo_count2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    run = 0; issue_ready = 0; redirect = 0; auto_ack = 1; man_ack = 0;
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    step();
    total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", mem_req); else passed++;
    total++; if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr got %h exp 00", mem_addr); else passed++;
    total++; if (fifo_count !== 2'd0) $display("FAIL reset_count got %0d exp 0", fifo_count); else passed++;
    total++; if (issue_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", issue_valid); else passed++;
    total++; if ({opcode, rs, rt, rd, imm, issue_pc} !== '0) $display("FAIL reset_fields got %h exp 0", {opcode, rs, rt, rd, imm, issue_pc}); else passed++;
    total++; if (mem_req2 !== 1'b0) $display("FAIL reset_mem_req_wrap got %b exp 0", mem_req2); else passed++;
    rst_n = 1;
  endtask

  task automatic test_stream();
    logic [7:0] exp_wrap [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run = 1; issue_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (mem_req !== 1'b1 || mem_addr !== 8'(i)) $display("FAIL stream_addr%0d got req=%b addr=%h exp req=1 addr=%h", i, mem_req, mem_addr, 8'(i)); else passed++;
      total++; if (mem_addr2 !== exp_wrap[i]) $display("FAIL wrap_addr%0d got %h exp %h", i, mem_addr2, exp_wrap[i]); else passed++;
      if (i >= 1) begin
        total++; if (issue_valid !== 1'b1 || issue_pc !== 8'(i - 1)) $display("FAIL stream_issue_pc%0d got v=%b pc=%h exp v=1 pc=%h", i, issue_valid, issue_pc, 8'(i - 1)); else passed++;
      end
      if (i == 1) begin
        total++; if (opcode !== 6'h00) $display("FAIL stream_op0 got %h exp 00", opcode); else passed++;
      end
      if (i == 2) begin
        total++; if (opcode !== 6'h08 || rt !== 5'd1 || imm !== 16'h0005 || rs !== 5'd0) $display("FAIL stream_word1 got op=%h rs=%h rt=%h imm=%h exp op=08 rs=00 rt=01 imm=0005", opcode, rs, rt, imm); else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    apply_reset();
    base = acks;
    run = 1; issue_ready = 0;
    repeat (6) step();
    total++; if (acks - base !== 2) $display("FAIL bp_acks got %0d exp 2", acks - base); else passed++;
    total++; if (fifo_count !== 2'd2 || mem_req !== 1'b0) $display("FAIL bp_full got count=%0d req=%b exp count=2 req=0", fifo_count, mem_req); else passed++;
    total++; if (issue_pc !== 8'h00) $display("FAIL bp_head got %h exp 00", issue_pc); else passed++;
    issue_ready = 1;
    step();
    total++; if (issue_pc !== 8'h01 || mem_req !== 1'b1 || mem_addr !== 8'h02) $display("FAIL bp_resume got pc=%h req=%b addr=%h exp pc=01 req=1 addr=02", issue_pc, mem_req, mem_addr); else passed++;
    step();
    total++; if (issue_pc !== 8'h02 || opcode !== 6'h0C || imm !== 16'h0002) $display("FAIL bp_word2 got pc=%h op=%h imm=%h exp pc=02 op=0c imm=0002", issue_pc, opcode, imm); else passed++;
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    auto_ack = 0; man_ack = 0;
    run = 1; issue_ready = 1;
    step();
    step();
    redirect = 1; redirect_pc = 8'h40;
    step();
    redirect = 0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) $display("FAIL rw_hold got req=%b addr=%h exp req=1 addr=00", mem_req, mem_addr); else passed++;
    step();
    man_ack = 1;
    step();
    man_ack = 0;
    total++; if (mem_addr !== 8'h40 || mem_req !== 1'b1) $display("FAIL rw_next_addr got req=%b addr=%h exp req=1 addr=40", mem_req, mem_addr); else passed++;
    total++; if (issue_valid !== 1'b0 || fifo_count !== 2'd0) $display("FAIL rw_dropped got v=%b count=%0d exp v=0 count=0", issue_valid, fifo_count); else passed++;
    auto_ack = 1;
    step();
    total++; if (issue_valid !== 1'b1 || issue_pc !== 8'h40 || opcode !== 6'h0C || imm !== 16'h0040) $display("FAIL rw_first_issue got v=%b pc=%h op=%h imm=%h exp v=1 pc=40 op=0c imm=0040", issue_valid, issue_pc, opcode, imm); else passed++;
  endtask

  task automatic test_redirect_ack();
    apply_reset();
    auto_ack = 0; man_ack = 0;
    run = 1; issue_ready = 0;
    step();
    man_ack = 1;
    step();
    total++; if (issue_valid !== 1'b1 || issue_pc !== 8'h00 || mem_addr !== 8'h01) $display("FAIL ra_setup got v=%b pc=%h addr=%h exp v=1 pc=00 addr=01", issue_valid, issue_pc, mem_addr); else passed++;
    redirect = 1; redirect_pc = 8'h40; issue_ready = 1;
    step();
    redirect = 0; man_ack = 0;
    total++; if (fifo_count !== 2'd0 || issue_valid !== 1'b0) $display("FAIL ra_flush got count=%0d v=%b exp count=0 v=0", fifo_count, issue_valid); else passed++;
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h40) $display("FAIL ra_next got req=%b addr=%h exp req=1 addr=40", mem_req, mem_addr); else passed++;
    auto_ack = 1;
    step();
    total++; if (issue_pc !== 8'h40 || fifo_count !== 2'd1) $display("FAIL ra_issue got pc=%h count=%0d exp pc=40 count=1", issue_pc, fifo_count); else passed++;
  endtask

  task automatic test_reset_midfetch();
    apply_reset();
    run = 1; issue_ready = 0;
    step();
    step();
    auto_ack = 0; man_ack = 0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h01 || fifo_count !== 2'd1) $display("FAIL rm_setup got req=%b addr=%h count=%0d exp req=1 addr=01 count=1", mem_req, mem_addr, fifo_count); else passed++;
    #2 rst_n = 0;
    #1;
    total++; if (mem_req !== 1'b0 || fifo_count !== 2'd0 || mem_addr !== 8'h00) $display("FAIL rm_async got req=%b count=%0d addr=%h exp req=0 count=0 addr=00", mem_req, fifo_count, mem_addr); else passed++;
    step();
    rst_n = 1; auto_ack = 1; issue_ready = 1;
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) $display("FAIL rm_restart got req=%b addr=%h exp req=1 addr=00", mem_req, mem_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack();
    test_reset_midfetch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
